// File: rtl/xor_frame_accumulator_if.sv
// xor_frame_accumulator_if: framed word stream in, checksum result out
interface xor_frame_accumulator_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_data;
    logic [LEN_W-1:0] down_len;
    logic             down_overflow;
    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_data, down_len, down_overflow
    );
    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_data, down_len, down_overflow
    );
endinterface

// File: rtl/xor_frame_accumulator.sv
// xor_frame_accumulator: folds each framed word stream into a mux-built XOR/XNOR checksum
module xfa_mux2 (
    input  logic sel,
    input  logic a0,
    input  logic a1,
    output logic y
);
    assign y = sel ? a1 : a0;
endmodule

module xor_frame_accumulator #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int INVERT  = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    xor_frame_accumulator_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, sum, res;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic             ovf, ovf_nx, accept, full, in_idle;
    assign in_idle      = state == IDLE;
    assign bus.up_ready   = state != OUT;
    assign bus.down_valid = state == OUT;
    assign accept       = bus.up_valid && bus.up_ready;
    assign full         = cnt == LEN_W'(MAX_LEN);
    assign cnt_nx       = full ? cnt : cnt + 1'b1;
    assign ovf_nx       = ovf | full;
    // each bit: operand gate, inverter, XOR select, optional output inverter -- all 2:1 muxes
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic opnd, opnd_n, sum_n;
        xfa_mux2 u_opnd (.sel(in_idle),      .a0(acc[i]), .a1(1'b0),   .y(opnd));
        xfa_mux2 u_inv  (.sel(opnd),         .a0(1'b1),   .a1(1'b0),   .y(opnd_n));
        xfa_mux2 u_xor  (.sel(bus.up_data[i]), .a0(opnd), .a1(opnd_n), .y(sum[i]));
        xfa_mux2 u_ninv (.sel(sum[i]),       .a0(1'b1),   .a1(1'b0),   .y(sum_n));
        xfa_mux2 u_pol  (.sel(INVERT != 0),  .a0(sum[i]), .a1(sum_n),  .y(res[i]));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == OUT) state_nx = bus.down_ready ? IDLE : OUT;
        else if (accept) state_nx = bus.up_last ? OUT : ACC;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc               <= '0;
            cnt               <= '0;
            ovf               <= 1'b0;
            bus.down_data     <= '0;
            bus.down_len      <= '0;
            bus.down_overflow <= 1'b0;
        end else begin
            if (accept) begin
                acc <= sum;
                cnt <= cnt_nx;
                ovf <= ovf_nx;
            end
            if (accept && bus.up_last) begin
                bus.down_data     <= res;
                bus.down_len      <= cnt_nx;
                bus.down_overflow <= ovf_nx;
            end
            if (state == OUT && bus.down_ready) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xor_frame_accumulator.sv
// tb_xor_frame_accumulator: three configurations fed one stream, results checked against a queued model
module tb_xor_frame_accumulator;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    xor_frame_accumulator_if #(.WIDTH(8), .MAX_LEN(16)) i0 ();
    xor_frame_accumulator_if #(.WIDTH(8), .MAX_LEN(16)) i1 ();
    xor_frame_accumulator_if #(.WIDTH(8), .MAX_LEN(4))  i2 ();
    xor_frame_accumulator #(.WIDTH(8), .MAX_LEN(16), .INVERT(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    xor_frame_accumulator #(.WIDTH(8), .MAX_LEN(16), .INVERT(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    xor_frame_accumulator #(.WIDTH(8), .MAX_LEN(4),  .INVERT(0)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

    typedef struct { logic [7:0] d; int l; logic o; } res_t;
    typedef struct { int n; logic [63:0] ws; logic [7:0] x; } frame_t;
    res_t q0[$], q1[$], q2[$];
    frame_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        i0.up_valid = v; i0.up_data = d; i0.up_last = l;
        i1.up_valid = v; i1.up_data = d; i1.up_last = l;
        i2.up_valid = v; i2.up_data = d; i2.up_last = l;
    endtask

    task automatic set_rdy(input logic r);
        i0.down_ready = r; i1.down_ready = r; i2.down_ready = r;
    endtask

    task automatic push_exp(input logic [7:0] x, input int n);
        q0.push_back('{x,  n > 16 ? 16 : n, n > 16});
        q1.push_back('{~x, n > 16 ? 16 : n, n > 16});
        q2.push_back('{x,  n > 4 ? 4 : n,   n > 4});
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        bit ok = 0;
        int t = 0;
        drive(1'b1, d, l);
        while (!ok && t < 20) begin
            ok = i0.up_ready;
            @(posedge clk); #1;
            t++;
        end
        drive(1'b0, 8'h00, 1'b0);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_word timeout actual up_ready 0 expected 1");
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        res_t e;
        if (i0.down_valid && i0.down_ready) begin
            if (q0.size() == 0) begin checks++; errors++; $display("FAIL d0 unexpected result actual %0h expected none", i0.down_data); end
            else begin e = q0.pop_front(); chk("d0 data", 32'(i0.down_data), 32'(e.d)); chk("d0 len", 32'(i0.down_len), e.l); chk("d0 ovf", 32'(i0.down_overflow), 32'(e.o)); end
        end
        if (i1.down_valid && i1.down_ready) begin
            if (q1.size() == 0) begin checks++; errors++; $display("FAIL d1 unexpected result actual %0h expected none", i1.down_data); end
            else begin e = q1.pop_front(); chk("d1 data", 32'(i1.down_data), 32'(e.d)); chk("d1 len", 32'(i1.down_len), e.l); chk("d1 ovf", 32'(i1.down_overflow), 32'(e.o)); end
        end
        if (i2.down_valid && i2.down_ready) begin
            if (q2.size() == 0) begin checks++; errors++; $display("FAIL d2 unexpected result actual %0h expected none", i2.down_data); end
            else begin e = q2.pop_front(); chk("d2 data", 32'(i2.down_data), 32'(e.d)); chk("d2 len", 32'(i2.down_len), e.l); chk("d2 ovf", 32'(i2.down_overflow), 32'(e.o)); end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1, 64'hA5,                 8'hA5},
            '{3, 64'h56_34_12,           8'h70},
            '{6, 64'h01_01_01_01_01_01,  8'h00},
            '{1, 64'h00,                 8'h00},
            '{4, 64'h01_F0_0F_FF,        8'h01},
            '{5, 64'h08_10_20_40_80,     8'hF8},
            '{2, 64'h3C_3C,              8'h00},
            '{1, 64'hFF,                 8'hFF}
        };
        drive(1'b0, 8'h00, 1'b0);
        set_rdy(1'b1);
        repeat (2) tick();
        chk("rst up_ready", 32'(i0.up_ready), 1);
        chk("rst down_valid", 32'(i0.down_valid), 0);
        chk("rst down_data", 32'(i0.down_data), 0);
        chk("rst down_len", 32'(i0.down_len), 0);
        chk("rst down_ovf", 32'(i0.down_overflow), 0);
        rst_n = 1;
        tick();
        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                send_word(tbl[i].ws[8*j +: 8], j == tbl[i].n - 1);
                if (i == 4 && j == 1) repeat (2) tick();
            end
            push_exp(tbl[i].x, tbl[i].n);
            chk("latency down_valid", 32'(i0.down_valid), 1);
            chk("latency up_ready", 32'(i0.up_ready), 0);
            chk("direct data", 32'(i0.down_data), 32'(tbl[i].x));
            tick();
            chk("post up_ready", 32'(i0.up_ready), 1);
            chk("post down_valid", 32'(i0.down_valid), 0);
        end
        set_rdy(1'b0);
        push_exp(8'h5A, 1);
        send_word(8'h5A, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp down_valid", 32'(i0.down_valid), 1);
            chk("bp data", 32'(i0.down_data), 32'h5A);
            chk("bp len", 32'(i0.down_len), 1);
            chk("bp up_ready", 32'(i0.up_ready), 0);
            drive(k[0], 8'hFF, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        set_rdy(1'b1);
        tick();
        chk("bp release down_valid", 32'(i0.down_valid), 0);
        chk("bp release up_ready", 32'(i0.up_ready), 1);
        chk("bp held data", 32'(i0.down_data), 32'h5A);
        tick();
        chk("bp no extra", 32'(i0.down_valid), 0);
        send_word(8'hFF, 1'b0);
        send_word(8'h0F, 1'b0);
        rst_n = 0;
        tick();
        chk("midrst up_ready", 32'(i0.up_ready), 1);
        chk("midrst down_valid", 32'(i0.down_valid), 0);
        chk("midrst down_len", 32'(i0.down_len), 0);
        rst_n = 1;
        tick();
        push_exp(8'h3C, 1);
        send_word(8'h3C, 1'b1);
        chk("midrst data", 32'(i0.down_data), 32'h3C);
        chk("midrst len", 32'(i0.down_len), 1);
        chk("midrst inv data", 32'(i1.down_data), 32'hC3);
        repeat (3) tick();
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        chk("q2 drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xor_frame_accumulator.md
# xor_frame_accumulator

Parametrised, sequential successor to the single-bit mux-built XOR gate. It accepts a stream of WIDTH-bit words framed by a `last` flag over a valid/ready handshake. It folds each frame into a bitwise XOR (optionally XNOR) checksum and returns the checksum, frame length and overflow flag on an output valid/ready handshake. It sits in the combinational-logic exercise track as the first block where the mux-based XOR is used inside a stateful datapath.

## Interface

- `WIDTH`, default 8: data word width in bits, ≥1.
- `MAX_LEN`, default 16: maximum counted frame length in words, ≥1.
- `INVERT`, default 0: 0 returns the XOR of the frame; 1 returns the bitwise complement of the XOR (XNOR checksum).
- `LEN_W`, derived as `$clog2(MAX_LEN+1)`: not overridable.

Ports:

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `up_valid` in 1: input word valid.
- `up_ready` out 1: block can accept an input word.
- `up_data` in WIDTH: input word.
- `up_last` in 1: word is the final word of its frame.
- `down_valid` out 1: checksum result valid.
- `down_ready` in 1: consumer accepts the result.
- `down_data` out WIDTH: frame checksum.
- `down_len` out LEN_W: number of words in the frame, saturated at MAX_LEN.
- `down_overflow` out 1: frame contained more than MAX_LEN words.

## Operation

- States:
  - IDLE: no words accepted yet in the current frame.
  - ACC: at least one non-last word accepted.
  - OUT: result is held for the consumer.
- `up_ready` = 1 in IDLE and ACC, and 0 in OUT. It is a pure decode of state.
- Accept means `up_valid && up_ready` at a rising edge.
- Accumulator `acc`, WIDTH bits:
  - Each accepted word updates `acc <= acc XOR up_data`.
  - In IDLE the XOR operand is 0, so `acc` is loaded with `up_data`.
- Per-bit XOR is built only from 2:1 mux instances and constants 0/1. The `^` operator is not used in the datapath. INVERT is applied with the same mux-inverter structure.
- Counter `cnt`:
  - Increments per accepted word and saturates at MAX_LEN.
  - A sticky `ovf` flag sets when a word is accepted while `cnt == MAX_LEN`.
- Transitions:
  - IDLE → ACC: accept with `up_last = 0`.
  - IDLE or ACC → OUT: accept with `up_last = 1`. The final result (acc XOR word, INVERT applied), the count and the overflow flag are registered onto the `down_*` outputs.
  - ACC → ACC: accept with `up_last = 0`.
  - OUT → IDLE: when `down_ready` is high. `acc`, `cnt` and `ovf` are cleared.
  - OUT → OUT: while `down_ready` is low. All `down_*` outputs are held stable.
- Idle cycles (`up_valid = 0`) in ACC leave all state unchanged. Frames may have gaps.
- `down_ready` is ignored outside OUT.
- A single-word frame (`up_last = 1` in IDLE) is legal and reports length 1.

## Timing

- Reset (asynchronous assert, synchronous release):
  - State IDLE.
  - `up_ready` = 1.
  - `down_valid` = 0, `down_data` = 0, `down_len` = 0, `down_overflow` = 0.
  - `acc`, `cnt`, `ovf` = 0.
- Latency: `down_valid` rises the cycle after the last word is accepted (1 cycle).
- `down_*` outputs change only on entry to OUT or on reset. After the OUT→IDLE handshake they keep their last value, with `down_valid` = 0.
- `up_ready` returns to 1 in the cycle after the output handshake. There is no same-cycle bypass.
- Throughput: one word per cycle inside a frame. The minimum frame period is 2 cycles (accept, then output handshake).
- Reset asserted mid-frame or in OUT immediately discards the partial or pending result. No result is emitted for that frame.

## Test plan

- Single word: WIDTH=8, INVERT=0, send 0xA5 with last; `down_ready`=1 → next cycle `down_valid`=1, data 0xA5, len 1, overflow 0. `up_ready` is 1 the following cycle.
- Three words: send 0x12, 0x34, 0x56(last) back-to-back → data 0x70, len 3, 1 cycle after the third accept.
- INVERT=1, same frame as the three-word test → data 0x8F, len 3.
- Backpressure: hold `down_ready`=0 for 5 cycles after a result → `down_valid`/data/len stable, `up_ready`=0, and `up_valid` pulses are ignored. Release → one handshake, then IDLE.
- Overflow: MAX_LEN=4, send six words of 0x01, the last with last → data 0x00, len 4, overflow 1. The next frame's overflow is 0.
- Reset mid-frame: send 0xFF, 0x0F, pull `rst_n` low for 1 cycle, then send 0x3C(last) → data 0x3C, len 1. No earlier result appears.
